cix32_alu_writeback: RTL
========================

# cix32_alu_writeback

Execute-to-writeback stage for CIX-32, directly downstream of the ALU. It latches each accepted ALU result in a one-entry valid/ready pipeline register. It merges 8/16-bit results into the old destination register value and updates the architectural EFLAGS register using a per-operation flag mask. It also feeds the registered CF back to the ALU `carry_in` for ADC/SBB chains.

## Interface
Parameters:
- EFLAGS_RESET, 32'h0000_0002, EFLAGS value after reset (bit 1 reserved, always 1)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  ALU result present
- in_ready  out  1  stage can accept
- in_op  in  alu_op_t  operation that produced the result
- in_result  in  32  ALU result, already zero-extended to size
- in_cf, in_zf, in_sf, in_of, in_pf, in_af  in  1 each  ALU flags
- in_is_8bit, in_is_16bit  in  1 each  operand size; both 0 means 32-bit; both 1 is illegal and treated as 8-bit
- in_shift_zero  in  1  shift/rotate count was 0
- in_wr_reg  in  1  destination written (0 for CMP/TEST)
- in_dest  in  3  destination register index
- in_dest_old  in  32  current value of the destination register
- flag_cmd  in  flag_cmd_t  FC_NONE/FC_CLC/FC_STC/FC_CMC
- out_valid  out  1  writeback pending
- out_ready  in  1  register file consumes
- out_we  out  1  register write enable (out_valid & captured in_wr_reg)
- out_dest  out  3  register index
- out_wdata  out  32  merged write data
- eflags  out  32  architectural EFLAGS
- carry_flag  out  1  eflags[0], to ALU carry_in

## Operation
- Accept = in_valid & in_ready; in_ready = ~out_valid | out_ready.
- Merge rule on accept:
  - 8-bit: {in_dest_old[31:8], in_result[7:0]}
  - 16-bit: {in_dest_old[31:16], in_result[15:0]}
  - 32-bit: in_result
- Flag mask per op (mask bits: CF, PF, AF, ZF, SF, OF):
  - ADD/SUB/CMP: all six.
  - INC/DEC: all except CF.
  - AND/OR/XOR/TEST: all six; AF forced 0; CF and OF taken from the ALU (0).
  - SHL/SHR/SAR: CF, PF, ZF, SF, OF; AF unchanged.
  - ROL/ROR: CF and OF only.
  - Shift/rotate with in_shift_zero=1: no flags change.
  - PASS_A/PASS_B/default: no flags change.
- flag_cmd is applied on every cycle, independent of accept:
  - CLC clears CF, STC sets CF, CMC inverts CF.
  - If an accept happens in the same cycle, the ALU update is applied first and the command second. CMC therefore inverts the newly produced CF.
- Bits other than CF/PF/AF/ZF/SF/OF hold their value; bit 1 stays 1.
- The output register holds its data while out_valid & ~out_ready.

## Timing
- Reset (asynchronous):
  - out_valid=0, out_we=0, out_dest=0, out_wdata=0
  - eflags=EFLAGS_RESET, carry_flag=0
- Latency is 1 cycle: out_* and eflags update on the accept edge.
- carry_flag is registered, so an ADC issued on the cycle after an ADD sees the ADD's CF. There is no combinational in→out path on flags.
- Throughput is 1 per cycle while out_ready=1; full stall when out_valid & ~out_ready.
- Simultaneous drain and accept (out_valid & out_ready & in_valid): new entry replaces the old one; out_valid stays 1.
- Drain with no accept: out_valid falls to 0 on the next edge.
- Reset mid-stall drops the pending entry; eflags returns to EFLAGS_RESET.

## Structure
- Add to the shared cix32_defines package:
  - flag_cmd_t enum
  - EFLAGS bit indices EF_CF=0, EF_PF=2, EF_AF=4, EF_ZF=6, EF_SF=7, EF_OF=11
  - a 6-bit flag_mask_t
- One combinational sub-module, cix32_flag_mask: (alu_op, shift_zero) -> flag_mask_t. It is shared with future decode-side flag-liveness logic.
- The top holds the output register, EFLAGS register and merge mux.

## Test plan
- ADD, 8-bit, in_result=0x00, in_cf=1, in_zf=1, in_dest_old=0x12345678 -> out_wdata=0x12345600, eflags CF=1 ZF=1; next-cycle ADC sees carry_flag=1.
- INC with in_cf=0 after STC -> CF stays 1; ZF/SF/OF/PF/AF follow the ALU.
- SHL with in_shift_zero=1, eflags=0x0000_08C3 -> eflags unchanged; out_wdata=in_result.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0; out_* stable; first beat delivered once, no duplicates or drops.
- Accept of SUB (in_cf=1) plus FC_CMC in the same cycle -> CF=0.
- Assert rst while out_valid=1 -> out_valid=0 and eflags=0x0000_0002 immediately, without a clock edge.

Source files
------------

// File: rtl/cix32_defines.sv
// Shared CIX-32 definitions: ALU operation codes, flag commands, EFLAGS bit
// positions and the per-operation flag update mask.
package cix32_defines;

  typedef enum logic [4:0] {
    OP_ADD,
    OP_ADC,
    OP_SUB,
    OP_SBB,
    OP_CMP,
    OP_INC,
    OP_DEC,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_TEST,
    OP_SHL,
    OP_SHR,
    OP_SAR,
    OP_ROL,
    OP_ROR,
    OP_PASS_A,
    OP_PASS_B
  } alu_op_t;

  typedef enum logic [1:0] {
    FC_NONE,
    FC_CLC,
    FC_STC,
    FC_CMC
  } flag_cmd_t;

  localparam int EF_CF = 0;
  localparam int EF_PF = 2;
  localparam int EF_AF = 4;
  localparam int EF_ZF = 6;
  localparam int EF_SF = 7;
  localparam int EF_OF = 11;

  typedef struct packed {
    logic of;
    logic sf;
    logic zf;
    logic af;
    logic pf;
    logic cf;
  } flag_mask_t;

  localparam flag_mask_t FM_NONE  = 6'b000000;
  localparam flag_mask_t FM_ALL   = 6'b111111;
  localparam flag_mask_t FM_NO_CF = 6'b111110;
  localparam flag_mask_t FM_SHIFT = 6'b111011;
  localparam flag_mask_t FM_ROT   = 6'b100001;

  // Logical ops write AF as 0 regardless of what the ALU reports.
  function automatic logic is_logic_op(alu_op_t op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) || (op == OP_TEST);
  endfunction

endpackage

// File: rtl/cix32_flag_mask.sv
// Maps an ALU operation to the set of EFLAGS bits it is allowed to update.
import cix32_defines::*;

module cix32_flag_mask (
  input  alu_op_t    alu_op,
  input  logic       shift_zero,
  output flag_mask_t mask
);

  always_comb begin
    mask = FM_NONE;
    case (alu_op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_CMP: mask = FM_ALL;
      OP_INC, OP_DEC:                         mask = FM_NO_CF;
      OP_AND, OP_OR, OP_XOR, OP_TEST:         mask = FM_ALL;
      // A zero shift/rotate count leaves every flag untouched.
      OP_SHL, OP_SHR, OP_SAR:                 mask = shift_zero ? FM_NONE : FM_SHIFT;
      OP_ROL, OP_ROR:                         mask = shift_zero ? FM_NONE : FM_ROT;
      default:                                mask = FM_NONE;
    endcase
  end

endmodule

// File: rtl/cix32_alu_writeback.sv
// Execute-to-writeback stage: one-entry result register with sub-word merge,
// plus the architectural EFLAGS register and the registered carry feedback.
import cix32_defines::*;

module cix32_alu_writeback #(
  parameter logic [31:0] EFLAGS_RESET = 32'h0000_0002
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  alu_op_t     in_op,
  input  logic [31:0] in_result,
  input  logic        in_cf,
  input  logic        in_zf,
  input  logic        in_sf,
  input  logic        in_of,
  input  logic        in_pf,
  input  logic        in_af,
  input  logic        in_is_8bit,
  input  logic        in_is_16bit,
  input  logic        in_shift_zero,
  input  logic        in_wr_reg,
  input  logic [2:0]  in_dest,
  input  logic [31:0] in_dest_old,
  input  flag_cmd_t   flag_cmd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_we,
  output logic [2:0]  out_dest,
  output logic [31:0] out_wdata,
  output logic [31:0] eflags,
  output logic        carry_flag
);

  logic        out_valid_reg;
  logic        wr_reg_reg;
  logic [2:0]  dest_reg;
  logic [31:0] wdata_reg;
  logic [31:0] eflags_reg;
  logic [31:0] eflags_next;
  logic [31:0] merge_data;
  logic        accept;
  flag_mask_t  mask;

  cix32_flag_mask u_flag_mask (
    .alu_op     (in_op),
    .shift_zero (in_shift_zero),
    .mask       (mask)
  );

  assign in_ready = ~out_valid_reg | out_ready;
  assign accept   = in_valid & in_ready;

  // 8-bit wins when both size bits are set.
  always_comb begin
    if (in_is_8bit)
      merge_data = {in_dest_old[31:8], in_result[7:0]};
    else if (in_is_16bit)
      merge_data = {in_dest_old[31:16], in_result[15:0]};
    else
      merge_data = in_result;
  end

  // ALU update first, then the flag command, so CMC acts on the fresh CF.
  always_comb begin
    eflags_next = eflags_reg;
    if (accept) begin
      if (mask.cf) eflags_next[EF_CF] = in_cf;
      if (mask.pf) eflags_next[EF_PF] = in_pf;
      if (mask.af) eflags_next[EF_AF] = in_af & ~is_logic_op(in_op);
      if (mask.zf) eflags_next[EF_ZF] = in_zf;
      if (mask.sf) eflags_next[EF_SF] = in_sf;
      if (mask.of) eflags_next[EF_OF] = in_of;
    end
    case (flag_cmd)
      FC_CLC:  eflags_next[EF_CF] = 1'b0;
      FC_STC:  eflags_next[EF_CF] = 1'b1;
      FC_CMC:  eflags_next[EF_CF] = ~eflags_next[EF_CF];
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      wr_reg_reg    <= 1'b0;
      dest_reg      <= 3'd0;
      wdata_reg     <= 32'd0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      wr_reg_reg    <= in_wr_reg;
      dest_reg      <= in_dest;
      wdata_reg     <= merge_data;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      eflags_reg <= EFLAGS_RESET;
    else
      eflags_reg <= eflags_next;
  end

  assign out_valid  = out_valid_reg;
  assign out_we     = out_valid_reg & wr_reg_reg;
  assign out_dest   = dest_reg;
  assign out_wdata  = wdata_reg;
  assign eflags     = eflags_reg;
  assign carry_flag = eflags_reg[EF_CF];

endmodule
